main_control_fsm: RTL

- Multi-cycle main control unit for the KGPRISC datapath; the producer side of the aluop/funct interface consumed by ALU_Control_Unit.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Per state, drives the datapath enables and the aluop/funct pair.
- Stalls on a memory-ready handshake.

---
 rtl/kgp_ctrl_pkg.sv | 51 +++++
 rtl/main_control_fsm_opcode_class_decoder.sv | 27 ++
 rtl/main_control_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGPRISC main control unit: FSM states, opcodes,
// opcode classes and the aluop classes consumed by ALU_Control_Unit.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_e;

    localparam logic [5:0] ADD_R   = 6'h00;
    localparam logic [5:0] COMP_R  = 6'h01;
    localparam logic [5:0] ADDI    = 6'h02;
    localparam logic [5:0] COMPI   = 6'h03;
    localparam logic [5:0] LOGIC_R = 6'h04;
    localparam logic [5:0] SHIFT_R = 6'h05;
    localparam logic [5:0] LW      = 6'h06;
    localparam logic [5:0] SW      = 6'h07;
    localparam logic [5:0] BR      = 6'h08;
    localparam logic [5:0] JMP     = 6'h09;
    localparam logic [5:0] HALT_OP = 6'h3F;

    typedef enum logic [3:0] {
        CLS_UNKNOWN,
        CLS_R_ARITH,
        CLS_I_ARITH,
        CLS_LOGIC,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT
    } opclass_e;

    localparam logic [2:0] ALUOP_R_ARITH = 3'b001;
    localparam logic [2:0] ALUOP_I_ARITH = 3'b010;
    localparam logic [2:0] ALUOP_LOGIC   = 3'b011;
    localparam logic [2:0] ALUOP_LDST    = 3'b101;
    localparam logic [2:0] ALUOP_BRANCH  = 3'b110;
    localparam logic [2:0] ALUOP_JUMP    = 3'b000;

    // Only R-type classes forward the function field to the ALU control unit.
    function automatic logic is_rtype(opclass_e c);
        return (c == CLS_R_ARITH) || (c == CLS_LOGIC);
    endfunction

endpackage

// File: rtl/main_control_fsm_opcode_class_decoder.sv
// Combinational opcode-to-class decode; anything not listed is CLS_UNKNOWN
// and is retired by the FSM as a NOP.
module opcode_class_decoder
    import kgp_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output opclass_e            class_o
);

    always_comb begin
        class_o = CLS_UNKNOWN;
        case (opcode_i)
            OPCODE_W'(ADD_R), OPCODE_W'(COMP_R):   class_o = CLS_R_ARITH;
            OPCODE_W'(ADDI), OPCODE_W'(COMPI):     class_o = CLS_I_ARITH;
            OPCODE_W'(LOGIC_R), OPCODE_W'(SHIFT_R): class_o = CLS_LOGIC;
            OPCODE_W'(LW):                         class_o = CLS_LOAD;
            OPCODE_W'(SW):                         class_o = CLS_STORE;
            OPCODE_W'(BR):                         class_o = CLS_BRANCH;
            OPCODE_W'(JMP):                        class_o = CLS_JUMP;
            OPCODE_W'(HALT_OP):                    class_o = CLS_HALT;
            default:                               class_o = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle KGPRISC main control FSM. Optional retired-instruction counter
// is built when KGP_RETIRE_COUNT_EN is defined.
module main_control_fsm
    import kgp_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               zero_flag,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] aluop,
    output logic [FUNCT_W-1:0] funct,
    output logic               branch_taken,
    output logic               halted,
    output logic [2:0]         state
`ifdef KGP_RETIRE_COUNT_EN
    , output logic [31:0]      retired_count
`endif
);

    state_e               state_q, state_d;
    opclass_e             cls_q, cls_d, dec_cls;
    logic [FUNCT_W-1:0]   funct_q, funct_d;

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31-OPCODE_W:FUNCT_W];

    opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode_i (instr[31:32-OPCODE_W]),
        .class_o  (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= CLS_UNKNOWN;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            funct_q <= funct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        funct_d = funct_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (mem_ready) state_d = DECODE;
            DECODE: begin
                // Class and funct are latched so EXECUTE/MEM stay Moore outputs.
                cls_d   = dec_cls;
                funct_d = is_rtype(dec_cls) ? instr[FUNCT_W-1:0] : '0;
                case (dec_cls)
                    CLS_UNKNOWN: state_d = FETCH;
                    CLS_HALT:    state_d = HALT;
                    default:     state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE:  state_d = MEM;
                    CLS_BRANCH, CLS_JUMP: state_d = FETCH;
                    CLS_R_ARITH, CLS_I_ARITH, CLS_LOGIC: state_d = WRITEBACK;
                    default:              state_d = FETCH;
                endcase
            end
            MEM: if (mem_ready) state_d = (cls_q == CLS_LOAD) ? WRITEBACK : FETCH;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        aluop        = '0;
        funct        = '0;
        branch_taken = 1'b0;
        halted       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            EXECUTE: begin
                funct = funct_q;
                case (cls_q)
                    CLS_R_ARITH: aluop = ALUOP_W'(ALUOP_R_ARITH);
                    CLS_I_ARITH: begin
                        aluop   = ALUOP_W'(ALUOP_I_ARITH);
                        alu_src = 1'b1;
                    end
                    CLS_LOGIC: aluop = ALUOP_W'(ALUOP_LOGIC);
                    CLS_LOAD, CLS_STORE: begin
                        aluop   = ALUOP_W'(ALUOP_LDST);
                        alu_src = 1'b1;
                    end
                    CLS_BRANCH: begin
                        aluop        = ALUOP_W'(ALUOP_BRANCH);
                        branch_taken = zero_flag;
                        pc_write     = zero_flag;
                    end
                    CLS_JUMP: begin
                        aluop        = ALUOP_W'(ALUOP_JUMP);
                        branch_taken = 1'b1;
                        pc_write     = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                iord      = 1'b1;
                aluop     = ALUOP_W'(ALUOP_LDST);
                funct     = funct_q;
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef KGP_RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retired_q;

    // Last cycle of each completed instruction; unknown opcodes and HALT never get here.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            EXECUTE:   retire = (cls_q == CLS_BRANCH) || (cls_q == CLS_JUMP);
            MEM:       retire = mem_ready && (cls_q == CLS_STORE);
            WRITEBACK: retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         retired_q <= '0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign retired_count = retired_q;
`endif

endmodule
